// File: rtl/reservation_station.sv
// reservation_station: collapsing-queue reservation station.
// Entry 0 is always the oldest entry. The oldest fully-ready entry is issued,
// and the entries above it shift down one slot on the same edge. Sources that
// are still waiting capture their value from the CDB.
module reservation_station #(
    parameter int unsigned NUM_UOPS      = 32,
    parameter int unsigned XLEN          = 32,
    parameter int unsigned PHYSFILE_SIZE = 256,
    parameter int unsigned ROB_SIZE      = 128,
    parameter int unsigned RSV_SIZE      = 8,
    localparam int unsigned UW = $clog2(NUM_UOPS),
    localparam int unsigned TW = $clog2(PHYSFILE_SIZE),
    localparam int unsigned RW = $clog2(ROB_SIZE),
    localparam int unsigned CW = $clog2(RSV_SIZE + 1),
    localparam int unsigned IW = (RSV_SIZE > 1) ? $clog2(RSV_SIZE) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            alloc_in,
    input  logic [UW-1:0]   uop_in,
    input  logic            eoi_in,
    input  logic            op1_rdy_in,
    input  logic            op2_rdy_in,
    input  logic [TW-1:0]   op1_tag_in,
    input  logic [TW-1:0]   op2_tag_in,
    input  logic [XLEN-1:0] op1_val_in,
    input  logic [XLEN-1:0] op2_val_in,
    input  logic [TW-1:0]   dest_tag_in,
    input  logic [31:0]     pc_in,
    input  logic [RW-1:0]   rob_entry_in,
    input  logic            cdb_valid,
    input  logic [TW-1:0]   cdb_tag,
    input  logic [XLEN-1:0] cdb_val,
    input  logic            fu_ready,
    output logic            full_out,
    output logic [CW-1:0]   count_out,
    output logic            issue_valid,
    output logic [UW-1:0]   issue_uop,
    output logic            issue_eoi,
    output logic [XLEN-1:0] issue_op1_val,
    output logic [XLEN-1:0] issue_op2_val,
    output logic [TW-1:0]   issue_dest_tag,
    output logic [31:0]     issue_pc,
    output logic [RW-1:0]   issue_rob_entry
);

    typedef struct packed {
        logic [UW-1:0]   uop;
        logic            eoi;
        logic [XLEN-1:0] val1;
        logic [XLEN-1:0] val2;
        logic [TW-1:0]   dest_tag;
        logic [31:0]     pc;
        logic [RW-1:0]   rob_entry;
    } payload_t;

    typedef struct packed {
        logic          valid;
        logic          rdy1;
        logic [TW-1:0] tag1;
        logic          rdy2;
        logic [TW-1:0] tag2;
        payload_t      pl;
    } entry_t;

    entry_t        ent_q [RSV_SIZE];
    entry_t        ent_d [RSV_SIZE];
    logic [CW-1:0] count_q, count_d;
    logic          issue_valid_q, issue_valid_d;
    payload_t      iss_q, iss_d;

    logic          found;
    logic [IW-1:0] sel;
    logic          fire;
    logic          do_alloc;
    logic [CW-1:0] alloc_pos;
    entry_t        new_ent;
    entry_t        shifted;

    // Select the lowest-index (oldest) entry with both sources ready
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int unsigned i = 0; i < RSV_SIZE; i++) begin
            if (!found && ent_q[IW'(i)].valid && ent_q[IW'(i)].rdy1 && ent_q[IW'(i)].rdy2) begin
                found = 1'b1;
                sel   = IW'(i);
            end
        end
    end

    assign fire      = found & fu_ready;
    assign full_out  = (count_q == CW'(RSV_SIZE));
    assign do_alloc  = alloc_in & ~full_out;
    // The tail slot moves down by one when an issue collapses the queue
    assign alloc_pos = count_q - CW'(fire);

    // Build the incoming entry, capturing a same-cycle CDB broadcast for waiting sources
    always_comb begin
        new_ent              = '0;
        new_ent.valid        = 1'b1;
        new_ent.rdy1         = op1_rdy_in;
        new_ent.tag1         = op1_tag_in;
        new_ent.rdy2         = op2_rdy_in;
        new_ent.tag2         = op2_tag_in;
        new_ent.pl.uop       = uop_in;
        new_ent.pl.eoi       = eoi_in;
        new_ent.pl.val1      = op1_val_in;
        new_ent.pl.val2      = op2_val_in;
        new_ent.pl.dest_tag  = dest_tag_in;
        new_ent.pl.pc        = pc_in;
        new_ent.pl.rob_entry = rob_entry_in;
        if (cdb_valid && !op1_rdy_in && (op1_tag_in == cdb_tag)) begin
            new_ent.rdy1    = 1'b1;
            new_ent.pl.val1 = cdb_val;
        end
        if (cdb_valid && !op2_rdy_in && (op2_tag_in == cdb_tag)) begin
            new_ent.rdy2    = 1'b1;
            new_ent.pl.val2 = cdb_val;
        end
    end

    // Next entry array: collapse above the issued slot, then wake up, then append
    always_comb begin
        shifted = '0;
        for (int unsigned j = 0; j < RSV_SIZE; j++) begin
            if (fire && (IW'(j) >= sel)) begin
                shifted = (j + 1 < RSV_SIZE) ? ent_q[IW'(j + 1)] : '0;
            end else begin
                shifted = ent_q[IW'(j)];
            end
            if (cdb_valid && shifted.valid) begin
                if (!shifted.rdy1 && (shifted.tag1 == cdb_tag)) begin
                    shifted.rdy1    = 1'b1;
                    shifted.pl.val1 = cdb_val;
                end
                if (!shifted.rdy2 && (shifted.tag2 == cdb_tag)) begin
                    shifted.rdy2    = 1'b1;
                    shifted.pl.val2 = cdb_val;
                end
            end
            if (do_alloc && (CW'(j) == alloc_pos)) begin
                shifted = new_ent;
            end
            ent_d[IW'(j)] = shifted;
        end
        count_d       = count_q + CW'(do_alloc) - CW'(fire);
        issue_valid_d = fire;
        iss_d         = fire ? ent_q[sel].pl : iss_q;
    end

    // State registers; reset and flush both clear every entry and the issue port
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            for (int unsigned k = 0; k < RSV_SIZE; k++) begin
                ent_q[IW'(k)] <= '0;
            end
            count_q       <= '0;
            issue_valid_q <= 1'b0;
            iss_q         <= '0;
        end else begin
            ent_q         <= ent_d;
            count_q       <= count_d;
            issue_valid_q <= issue_valid_d;
            iss_q         <= iss_d;
        end
    end

    assign count_out       = count_q;
    assign issue_valid     = issue_valid_q;
    assign issue_uop       = iss_q.uop;
    assign issue_eoi       = iss_q.eoi;
    assign issue_op1_val   = iss_q.val1;
    assign issue_op2_val   = iss_q.val2;
    assign issue_dest_tag  = iss_q.dest_tag;
    assign issue_pc        = iss_q.pc;
    assign issue_rob_entry = iss_q.rob_entry;

endmodule

// File: tb/tb_reservation_station.sv
// tb_reservation_station: directed vectors with hand-computed expectations.
module tb_reservation_station;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        alloc_in;
    logic [4:0]  uop_in;
    logic        eoi_in;
    logic        op1_rdy_in, op2_rdy_in;
    logic [7:0]  op1_tag_in, op2_tag_in;
    logic [31:0] op1_val_in, op2_val_in;
    logic [7:0]  dest_tag_in;
    logic [31:0] pc_in;
    logic [6:0]  rob_entry_in;
    logic        cdb_valid;
    logic [7:0]  cdb_tag;
    logic [31:0] cdb_val;
    logic        fu_ready;
    logic        full_out;
    logic [3:0]  count_out;
    logic        issue_valid;
    logic [4:0]  issue_uop;
    logic        issue_eoi;
    logic [31:0] issue_op1_val, issue_op2_val;
    logic [7:0]  issue_dest_tag;
    logic [31:0] issue_pc;
    logic [6:0]  issue_rob_entry;

    int n_cmp = 0;
    int n_err = 0;

    reservation_station #(
        .NUM_UOPS(32), .XLEN(32), .PHYSFILE_SIZE(256), .ROB_SIZE(128), .RSV_SIZE(8)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush), .alloc_in(alloc_in),
        .uop_in(uop_in), .eoi_in(eoi_in),
        .op1_rdy_in(op1_rdy_in), .op2_rdy_in(op2_rdy_in),
        .op1_tag_in(op1_tag_in), .op2_tag_in(op2_tag_in),
        .op1_val_in(op1_val_in), .op2_val_in(op2_val_in),
        .dest_tag_in(dest_tag_in), .pc_in(pc_in), .rob_entry_in(rob_entry_in),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
        .fu_ready(fu_ready), .full_out(full_out), .count_out(count_out),
        .issue_valid(issue_valid), .issue_uop(issue_uop), .issue_eoi(issue_eoi),
        .issue_op1_val(issue_op1_val), .issue_op2_val(issue_op2_val),
        .issue_dest_tag(issue_dest_tag), .issue_pc(issue_pc),
        .issue_rob_entry(issue_rob_entry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // dest tag, pc and eoi are derived from the ROB index so they can be checked too
    task automatic set_alloc(input logic [4:0] u, input logic r1, input logic [7:0] t1,
                             input logic [31:0] v1, input logic r2, input logic [7:0] t2,
                             input logic [31:0] v2, input logic [6:0] rob);
        alloc_in     = 1'b1;
        uop_in       = u;
        op1_rdy_in   = r1;
        op1_tag_in   = t1;
        op1_val_in   = v1;
        op2_rdy_in   = r2;
        op2_tag_in   = t2;
        op2_val_in   = v2;
        rob_entry_in = rob;
        dest_tag_in  = 8'(rob) + 8'd1;
        pc_in        = 32'h1000 + 32'(rob) * 4;
        eoi_in       = rob[0];
    endtask

    task automatic cdb(input logic [7:0] t, input logic [31:0] v);
        cdb_valid = 1'b1;
        cdb_tag   = t;
        cdb_val   = v;
    endtask

    task automatic idle();
        alloc_in  = 1'b0;
        cdb_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; fu_ready = 1'b0;
        alloc_in = 1'b0; uop_in = '0; eoi_in = 1'b0;
        op1_rdy_in = 1'b0; op2_rdy_in = 1'b0; op1_tag_in = '0; op2_tag_in = '0;
        op1_val_in = '0; op2_val_in = '0; dest_tag_in = '0; pc_in = '0; rob_entry_in = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_val = '0;

        // reset state
        tick(); tick();
        check("rst_count", 32'(count_out), 0);
        check("rst_full", 32'(full_out), 0);
        check("rst_iv", 32'(issue_valid), 0);
        check("rst_op1", issue_op1_val, 0);
        check("rst_pc", issue_pc, 0);
        check("rst_rob", 32'(issue_rob_entry), 0);
        rst = 1'b1;

        // single fully-ready uop
        fu_ready = 1'b1;
        set_alloc(5'd3, 1, 8'd1, 32'h5, 1, 8'd2, 32'h7, 7'd9);
        tick(); idle();
        check("t1_cnt1", 32'(count_out), 1);
        check("t1_iv0", 32'(issue_valid), 0);
        tick();
        check("t1_iv", 32'(issue_valid), 1);
        check("t1_op1", issue_op1_val, 32'h5);
        check("t1_op2", issue_op2_val, 32'h7);
        check("t1_rob", 32'(issue_rob_entry), 9);
        check("t1_pc", issue_pc, 32'h1024);
        check("t1_uop", 32'(issue_uop), 3);
        check("t1_dest", 32'(issue_dest_tag), 10);
        check("t1_eoi", 32'(issue_eoi), 1);
        check("t1_cnt0", 32'(count_out), 0);
        tick();
        check("t1_pulse", 32'(issue_valid), 0);
        check("t1_hold", issue_op1_val, 32'h5);

        // wakeup on op1, wrong tag ignored
        set_alloc(5'd4, 0, 8'd12, 32'hDEAD, 1, 8'd2, 32'h33, 7'd11);
        tick(); idle();
        tick();
        check("t2_wait", 32'(issue_valid), 0);
        cdb(8'd13, 32'h55);
        tick(); idle();
        check("t2_tag13", 32'(issue_valid), 0);
        cdb(8'd12, 32'hAB);
        tick(); idle();
        check("t2_nosame", 32'(issue_valid), 0);
        tick();
        check("t2_iv", 32'(issue_valid), 1);
        check("t2_op1", issue_op1_val, 32'hAB);
        check("t2_op2", issue_op2_val, 32'h33);
        check("t2_cnt", 32'(count_out), 0);

        // both sources woken independently
        set_alloc(5'd5, 0, 8'd70, 32'h0, 0, 8'd71, 32'h0, 7'd12);
        tick(); idle();
        cdb(8'd70, 32'h11);
        tick(); idle();
        tick();
        check("t2b_half", 32'(issue_valid), 0);
        cdb(8'd71, 32'h22);
        tick(); idle();
        tick();
        check("t2b_iv", 32'(issue_valid), 1);
        check("t2b_op1", issue_op1_val, 32'h11);
        check("t2b_op2", issue_op2_val, 32'h22);
        check("t2b_rob", 32'(issue_rob_entry), 12);

        // ordering and collapse
        fu_ready = 1'b0;
        set_alloc(5'd1, 0, 8'd3, 32'h0, 1, 8'd0, 32'hA2, 7'd20);
        tick();
        set_alloc(5'd2, 1, 8'd0, 32'hB1, 1, 8'd0, 32'hB2, 7'd21);
        tick();
        set_alloc(5'd3, 1, 8'd0, 32'hC1, 1, 8'd0, 32'hC2, 7'd22);
        tick(); idle();
        check("t3_cnt3", 32'(count_out), 3);
        fu_ready = 1'b1;
        tick();
        check("t3_b_rob", 32'(issue_rob_entry), 21);
        check("t3_b_op1", issue_op1_val, 32'hB1);
        check("t3_cnt2", 32'(count_out), 2);
        tick();
        check("t3_c_rob", 32'(issue_rob_entry), 22);
        check("t3_c_op2", issue_op2_val, 32'hC2);
        check("t3_cnt1", 32'(count_out), 1);
        tick();
        check("t3_idle", 32'(issue_valid), 0);
        cdb(8'd3, 32'hA1);
        tick(); idle();
        tick();
        check("t3_a_iv", 32'(issue_valid), 1);
        check("t3_a_rob", 32'(issue_rob_entry), 20);
        check("t3_a_op1", issue_op1_val, 32'hA1);
        check("t3_a_op2", issue_op2_val, 32'hA2);
        check("t3_cnt0", 32'(count_out), 0);

        // full and back-pressure
        fu_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            set_alloc(5'(k), 0, 8'(100 + k), 32'h0, 1, 8'd0, 32'(k), 7'(40 + k));
            tick();
        end
        idle();
        check("t4_full", 32'(full_out), 1);
        check("t4_cnt8", 32'(count_out), 8);
        set_alloc(5'd9, 1, 8'd0, 32'h1, 1, 8'd0, 32'h2, 7'd99);
        tick(); idle();
        check("t4_drop_cnt", 32'(count_out), 8);
        cdb(8'd102, 32'h77);
        tick(); idle();
        fu_ready = 1'b1;
        set_alloc(5'd9, 1, 8'd0, 32'h1, 1, 8'd0, 32'h2, 7'd99);
        tick(); idle();
        check("t4_iss_iv", 32'(issue_valid), 1);
        check("t4_iss_rob", 32'(issue_rob_entry), 42);
        check("t4_iss_op1", issue_op1_val, 32'h77);
        check("t4_iss_op2", issue_op2_val, 32'h2);
        check("t4_cnt7", 32'(count_out), 7);
        check("t4_notfull", 32'(full_out), 0);
        tick();
        check("t4_dropped", 32'(issue_valid), 0);
        cdb(8'd103, 32'h88);
        tick(); idle();
        tick();
        check("t4_rob43", 32'(issue_rob_entry), 43);
        check("t4_op1_88", issue_op1_val, 32'h88);
        check("t4_cnt6", 32'(count_out), 6);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t4_flush_cnt", 32'(count_out), 0);

        // allocation bypass; a ready source is not overwritten
        fu_ready = 1'b1;
        set_alloc(5'd6, 0, 8'd40, 32'hBAD, 1, 8'd40, 32'h22, 7'd50);
        cdb(8'd40, 32'h99);
        tick(); idle();
        check("t5_cnt1", 32'(count_out), 1);
        tick();
        check("t5_iv", 32'(issue_valid), 1);
        check("t5_op1", issue_op1_val, 32'h99);
        check("t5_op2", issue_op2_val, 32'h22);
        check("t5_rob", 32'(issue_rob_entry), 50);

        // simultaneous alloc and issue
        fu_ready = 1'b0;
        set_alloc(5'd7, 1, 8'd0, 32'h1, 1, 8'd0, 32'h2, 7'd60);
        tick();
        set_alloc(5'd8, 0, 8'd50, 32'h0, 1, 8'd0, 32'h3, 7'd61);
        tick(); idle();
        check("t5s_cnt2", 32'(count_out), 2);
        fu_ready = 1'b1;
        set_alloc(5'd9, 0, 8'd51, 32'h0, 1, 8'd0, 32'h4, 7'd62);
        tick(); idle();
        check("t5s_rob60", 32'(issue_rob_entry), 60);
        check("t5s_cnt_same", 32'(count_out), 2);
        fu_ready = 1'b0;
        cdb(8'd51, 32'h5151);
        tick();
        cdb(8'd50, 32'h5050);
        tick(); idle();
        fu_ready = 1'b1;
        tick();
        check("t5s_y_rob", 32'(issue_rob_entry), 61);
        check("t5s_y_op1", issue_op1_val, 32'h5050);
        check("t5s_cnt1", 32'(count_out), 1);
        tick();
        check("t5s_z_rob", 32'(issue_rob_entry), 62);
        check("t5s_z_op1", issue_op1_val, 32'h5151);
        check("t5s_cnt0", 32'(count_out), 0);

        // flush mid-operation
        fu_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            set_alloc(5'(k), 0, 8'(60 + k), 32'h0, 1, 8'd0, 32'h0, 7'(70 + k));
            tick();
        end
        set_alloc(5'd1, 1, 8'd0, 32'h66, 1, 8'd0, 32'h67, 7'd75);
        tick(); idle();
        check("t6_cnt6", 32'(count_out), 6);
        fu_ready = 1'b1;
        tick();
        check("t6_iv", 32'(issue_valid), 1);
        check("t6_rob", 32'(issue_rob_entry), 75);
        check("t6_cnt5", 32'(count_out), 5);
        flush = 1'b1;
        cdb(8'd60, 32'h600);
        set_alloc(5'd2, 1, 8'd0, 32'h1, 1, 8'd0, 32'h1, 7'd76);
        tick();
        flush = 1'b0; idle();
        check("t6_fl_cnt", 32'(count_out), 0);
        check("t6_fl_iv", 32'(issue_valid), 0);
        check("t6_fl_rob", 32'(issue_rob_entry), 0);
        check("t6_fl_op1", issue_op1_val, 0);
        check("t6_fl_full", 32'(full_out), 0);
        tick(); tick();
        check("t6_after_cnt", 32'(count_out), 0);
        check("t6_after_iv", 32'(issue_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
